// File: rtl/seg7_display_ctrl_pkg.sv
// Shared seven-segment types, bus widths, register map and hex decoder.
package seg7_display_ctrl_pkg;

    localparam int BUS_ADDR_ = 15;
    localparam int BUS_DATA_ = 31;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
        logic g;
        logic p;
    } seg7p_t;

    localparam logic [2:0] SEG_REG_HEX    = 3'd0;
    localparam logic [2:0] SEG_REG_DP     = 3'd1;
    localparam logic [2:0] SEG_REG_BLINK  = 3'd2;
    localparam logic [2:0] SEG_REG_CTRL   = 3'd3;
    localparam logic [2:0] SEG_REG_RAW_LO = 3'd4;
    localparam logic [2:0] SEG_REG_RAW_HI = 3'd5;

    localparam int SEG_CTRL_EN     = 0;
    localparam int SEG_CTRL_RAW    = 1;
    localparam int SEG_CTRL_SCROLL = 2;

    // Active-high segments, p left clear for the caller to fill in.
    function automatic seg7p_t seg7_hex_decode(input logic [3:0] nib);
        logic [6:0] abcdefg;
        case (nib)
            4'h0:    abcdefg = 7'b1111110;
            4'h1:    abcdefg = 7'b0110000;
            4'h2:    abcdefg = 7'b1101101;
            4'h3:    abcdefg = 7'b1111001;
            4'h4:    abcdefg = 7'b0110011;
            4'h5:    abcdefg = 7'b1011011;
            4'h6:    abcdefg = 7'b1011111;
            4'h7:    abcdefg = 7'b1110000;
            4'h8:    abcdefg = 7'b1111111;
            4'h9:    abcdefg = 7'b1111011;
            4'hA:    abcdefg = 7'b1110111;
            4'hB:    abcdefg = 7'b0011111;
            4'hC:    abcdefg = 7'b1001110;
            4'hD:    abcdefg = 7'b0111101;
            4'hE:    abcdefg = 7'b1001111;
            default: abcdefg = 7'b1000111;
        endcase
        return seg7p_t'({abcdefg, 1'b0});
    endfunction

endpackage

// File: rtl/seg7_display_ctrl_tick_prescaler.sv
// Free-running divider: one-cycle tick every DIV enabled cycles; combinational tick.
// Dropping en clears the count so the next enable starts a fresh period.
module tick_prescaler #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = en && (cnt_q == CW'(DIV - 1));
        cnt_d = cnt_q + 1'b1;
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Bus-mapped seven-segment bank controller with hardware blink and rotate-scroll.
// Access acked one cycle after accept (no wait states); seg registered, one cycle after a write.
module seg7_display_ctrl
    import seg7_display_ctrl_pkg::*;
#(
    parameter int DIGITS     = 6,
    parameter int CLK_HZ     = 50_000_000,
    parameter int BLINK_HZ   = 2,
    parameter int SCROLL_HZ  = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BUS_ADDR_:0]  bus_addr,
    input  logic [BUS_DATA_:0]  bus_wdata,
    input  logic                bus_we,
    input  logic                bus_re,
    output logic [BUS_DATA_:0]  bus_rdata,
    output logic                bus_ack,
    output seg7p_t [DIGITS-1:0] seg
);
    localparam int     DW         = BUS_DATA_ + 1;
    localparam int     HW         = 4 * DIGITS;
    localparam int     RW         = 8 * DIGITS;
    localparam int     OFF_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int     BLINK_DIV  = CLK_HZ / (2 * BLINK_HZ);
    localparam int     SCROLL_DIV = CLK_HZ / SCROLL_HZ;
    localparam seg7p_t DARK       = (ACTIVE_LOW != 0) ? seg7p_t'(8'hFF) : seg7p_t'(8'h00);

    logic [HW-1:0]     hex_q, hex_d;
    logic [DIGITS-1:0] dp_q, dp_d;
    logic [DIGITS-1:0] blink_q, blink_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [RW-1:0]     raw_q, raw_d;
    logic              ack_q, ack_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              phase_q, phase_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    seg7p_t [DIGITS-1:0] seg_q, seg_d;

    logic [2:0]        reg_idx;
    logic              accept;
    logic              wr;
    logic [DW-1:0]     rd_val;
    logic              en;
    logic              blink_tick;
    logic              scroll_tick;
    logic [HW-1:0]     hex_rot;
    logic [RW-1:0]     raw_rot;
    logic [DIGITS-1:0] dp_rot;
    logic [DIGITS-1:0] blink_rot;
    logic              unused_bits;

    assign unused_bits = ^{bus_addr[BUS_ADDR_:5], bus_addr[1:0], bus_wdata};

    assign en      = ctrl_q[SEG_CTRL_EN];
    assign reg_idx = bus_addr[4:2];
    assign accept  = (bus_we | bus_re) & ~ack_q;
    assign wr      = accept & bus_we;

    tick_prescaler #(.DIV(BLINK_DIV)) u_blink_pre (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (blink_tick)
    );

    tick_prescaler #(.DIV(SCROLL_DIV)) u_scroll_pre (
        .clk  (clk),
        .rst  (rst),
        .en   (en & ctrl_q[SEG_CTRL_SCROLL]),
        .tick (scroll_tick)
    );

    // Read mux sees pre-write state, so a combined we+re returns the old value.
    always_comb begin
        rd_val = '0;
        case (reg_idx)
            SEG_REG_HEX:   rd_val = DW'(hex_q);
            SEG_REG_DP:    rd_val = DW'(dp_q);
            SEG_REG_BLINK: rd_val = DW'(blink_q);
            SEG_REG_CTRL:  rd_val = DW'(ctrl_q);
            SEG_REG_RAW_LO: begin
                for (int i = 0; i < DIGITS && i < 4; i++) begin
                    rd_val[8*i +: 8] = raw_q[8*i +: 8];
                end
            end
            SEG_REG_RAW_HI: begin
                for (int i = 4; i < DIGITS; i++) begin
                    rd_val[8*(i-4) +: 8] = raw_q[8*i +: 8];
                end
            end
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        hex_d   = hex_q;
        dp_d    = dp_q;
        blink_d = blink_q;
        ctrl_d  = ctrl_q;
        raw_d   = raw_q;
        ack_d   = accept;
        rdata_d = accept ? rd_val : '0;
        if (wr) begin
            case (reg_idx)
                SEG_REG_HEX:   hex_d   = bus_wdata[HW-1:0];
                SEG_REG_DP:    dp_d    = bus_wdata[DIGITS-1:0];
                SEG_REG_BLINK: blink_d = bus_wdata[DIGITS-1:0];
                SEG_REG_CTRL:  ctrl_d  = bus_wdata[2:0];
                SEG_REG_RAW_LO: begin
                    for (int i = 0; i < DIGITS && i < 4; i++) begin
                        raw_d[8*i +: 8] = bus_wdata[8*i +: 8];
                    end
                end
                SEG_REG_RAW_HI: begin
                    for (int i = 4; i < DIGITS; i++) begin
                        raw_d[8*i +: 8] = bus_wdata[8*(i-4) +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (!en) begin
            phase_d = 1'b0;
        end else if (blink_tick) begin
            phase_d = ~phase_q;
        end
        offset_d = offset_q;
        if (scroll_tick) begin
            offset_d = (offset_q == OFF_W'(DIGITS - 1)) ? '0 : offset_q + 1'b1;
        end
        // Turning scroll off through CTRL snaps the display home on the same edge.
        if (wr && (reg_idx == SEG_REG_CTRL) && !bus_wdata[SEG_CTRL_SCROLL]) begin
            offset_d = '0;
        end
    end

    // Rotate every per-digit source field together so blink and DP follow the content.
    always_comb begin
        hex_rot   = HW'({hex_q, hex_q} >> {offset_q, 2'b00});
        raw_rot   = RW'({raw_q, raw_q} >> {offset_q, 3'b000});
        dp_rot    = DIGITS'({dp_q, dp_q} >> offset_q);
        blink_rot = DIGITS'({blink_q, blink_q} >> offset_q);
    end

    always_comb begin
        seg_d = seg_q;
        for (int i = 0; i < DIGITS; i++) begin : g_digit
            seg7p_t s;
            if (ctrl_q[SEG_CTRL_RAW]) begin
                s = seg7p_t'(raw_rot[8*i +: 8]);
            end else begin
                s   = seg7_hex_decode(hex_rot[4*i +: 4]);
                s.p = dp_rot[i];
            end
            if (!en || (blink_rot[i] && phase_q)) begin
                s = '0;
            end
            if (ACTIVE_LOW != 0) begin
                seg_d[i] = seg7p_t'(~s);
            end else begin
                seg_d[i] = s;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_q    <= '0;
            dp_q     <= '0;
            blink_q  <= '0;
            ctrl_q   <= '0;
            raw_q    <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            phase_q  <= 1'b0;
            offset_q <= '0;
            seg_q    <= {DIGITS{DARK}};
        end else begin
            hex_q    <= hex_d;
            dp_q     <= dp_d;
            blink_q  <= blink_d;
            ctrl_q   <= ctrl_d;
            raw_q    <= raw_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            phase_q  <= phase_d;
            offset_q <= offset_d;
            seg_q    <= seg_d;
        end
    end

    assign bus_ack   = ack_q;
    assign bus_rdata = rdata_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Randomized bench for seg7_display_ctrl against a digit-level reference model.
`timescale 1ns/1ps
module tb_seg7_display_ctrl;
    import seg7_display_ctrl_pkg::*;

    localparam int D    = 6;
    localparam int BDIV = 4;
    localparam int SDIV = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [BUS_ADDR_:0]  bus_addr;
    logic [BUS_DATA_:0]  bus_wdata;
    logic                bus_we;
    logic                bus_re;
    logic [BUS_DATA_:0]  bus_rdata;
    logic                bus_ack;
    seg7p_t [D-1:0]      seg;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg7_display_ctrl #(
        .DIGITS(D), .CLK_HZ(8), .BLINK_HZ(1), .SCROLL_HZ(1), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .seg(seg)
    );

    // Reference model: register contents plus counts of enabled clock edges.
    logic [31:0] m_hex = '0, m_dp = '0, m_blink = '0, m_ctrl = '0, m_rlo = '0, m_rhi = '0;
    int          m_bcnt = 0, m_scnt = 0, m_off = 0;
    logic [7:0]  exp_seg [D];

    string hex_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [7:0] letters(string s);
        logic [7:0] v;
        v = 8'h00;
        for (int k = 0; k < s.len(); k++) v[7 - (int'(s[k]) - 97)] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] model_seg(int i);
        int         src;
        logic [7:0] v;
        src = (i + m_off) % D;
        if (!m_ctrl[0]) return 8'hFF;
        if (m_ctrl[1]) begin
            if (src < 4) v = m_rlo[src*8 +: 8];
            else         v = m_rhi[(src-4)*8 +: 8];
        end else begin
            v = letters(hex_str[m_hex[src*4 +: 4]]) | {7'b0, m_dp[src]};
        end
        if (m_blink[src] && ((m_bcnt / BDIV) % 2 == 1)) v = 8'h00;
        return ~v;
    endfunction

    function automatic logic [31:0] model_read(logic [2:0] idx);
        case (idx)
            3'd0:    return m_hex;
            3'd1:    return m_dp;
            3'd2:    return m_blink;
            3'd3:    return m_ctrl;
            3'd4:    return m_rlo;
            3'd5:    return m_rhi;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_write(logic [2:0] idx, logic [31:0] d);
        case (idx)
            3'd0: m_hex   = d & 32'h00FF_FFFF;
            3'd1: m_dp    = d & 32'h3F;
            3'd2: m_blink = d & 32'h3F;
            3'd3: begin
                m_ctrl = d & 32'h7;
                if (!d[2]) m_off = 0;
            end
            3'd4: m_rlo   = d;
            3'd5: m_rhi   = d & 32'hFFFF;
            default: ;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_hex = '0; m_dp = '0; m_blink = '0; m_ctrl = '0; m_rlo = '0; m_rhi = '0;
                m_bcnt = 0; m_scnt = 0; m_off = 0;
                for (int i = 0; i < D; i++) exp_seg[i] = 8'hFF;
            end else begin
                for (int i = 0; i < D; i++) exp_seg[i] = model_seg(i);
                if (m_ctrl[0]) m_bcnt++;
                else           m_bcnt = 0;
                if (m_ctrl[0] && m_ctrl[2]) begin
                    m_scnt++;
                    if (m_scnt == SDIV) begin
                        m_scnt = 0;
                        m_off  = (m_off + 1) % D;
                    end
                end else begin
                    m_scnt = 0;
                end
            end
        end
    end

    // Bus master: holds the request one edge past ack, then reports ack at that point.
    task automatic bus_access(input logic we, input logic re, input logic [2:0] idx,
                              input logic [31:0] wd, output logic [31:0] rd,
                              output logic [31:0] erd, output int lat, output logic ack2);
        lat = 0;
        rd  = '0;
        erd = model_read(idx);
        @(negedge clk);
        bus_addr      = 16'($urandom);
        bus_addr[4:2] = idx;
        bus_we        = we;
        bus_re        = re;
        bus_wdata     = wd;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (bus_ack) begin
                lat = n;
                rd  = bus_rdata;
                erd = model_read(idx);
                if (we) model_write(idx, wd);
            end
        end
        @(posedge clk); #1;
        ack2   = bus_ack;
        bus_we = 1'b0;
        bus_re = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd, erd;
        int          lat;
        logic        a2;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_ack !== 1'b0 || bus_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus ack=%b rdata=%h expected ack=0 rdata=0", bus_ack, bus_rdata);
        end
        for (int i = 0; i < D; i++) begin
            checks++;
            if (seg[i] !== 8'hFF) begin
                failures++;
                $display("FAIL reset_seg digit%0d got=%h expected=ff", i, seg[i]);
            end
        end
        rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            bus_access(1'b0, 1'b1, 3'(r), 32'h0, rd, erd, lat, a2);
            checks++;
            if (lat !== 1 || a2 !== 1'b0 || rd !== 32'h0) begin
                failures++;
                $display("FAIL reset_read reg%0d lat=%0d ack2=%b rd=%h expected lat=1 ack2=0 rd=0",
                         r, lat, a2, rd);
            end
        end
        @(negedge clk);
        checks++;
        if (seg !== {D{8'hFF}}) begin
            failures++;
            $display("FAIL reset_dark got=%h expected all ff", seg);
        end
    endtask

    task automatic test_hex();
        logic [31:0] rd, erd;
        int          lat;
        logic        a2;
        bus_access(1'b1, 1'b0, SEG_REG_CTRL, 32'h1, rd, erd, lat, a2);
        checks++;
        if (lat !== 1 || a2 !== 1'b0) begin
            failures++;
            $display("FAIL hex_ctrl_ack lat=%0d ack2=%b expected lat=1 ack2=0", lat, a2);
        end
        bus_access(1'b1, 1'b0, SEG_REG_HEX, 32'h0054_3210, rd, erd, lat, a2);
        @(negedge clk);
        checks++;
        if (seg[0] !== 8'h03 || seg[1] !== 8'h9F) begin
            failures++;
            $display("FAIL hex_digit01 got=%h,%h expected=03,9f", seg[0], seg[1]);
        end
        for (int i = 0; i < D; i++) begin
            checks++;
            if (seg[i] !== exp_seg[i]) begin
                failures++;
                $display("FAIL hex_digit%0d got=%h expected=%h", i, seg[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_blink();
        logic [31:0] rd, erd;
        int          lat, dark_n, p_off;
        logic        a2;
        bus_access(1'b1, 1'b0, SEG_REG_DP, 32'h1, rd, erd, lat, a2);
        bus_access(1'b1, 1'b0, SEG_REG_BLINK, 32'h2, rd, erd, lat, a2);
        dark_n = 0;
        p_off  = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (seg[1] === 8'hFF) dark_n++;
            if (seg[0][0] !== 1'b0) p_off++;
            for (int i = 0; i < D; i++) begin
                checks++;
                if (seg[i] !== exp_seg[i]) begin
                    failures++;
                    $display("FAIL blink c%0d digit%0d got=%h expected=%h", c, i, seg[i], exp_seg[i]);
                end
            end
        end
        checks++;
        if (dark_n !== 16 || p_off !== 0) begin
            failures++;
            $display("FAIL blink_duty dark=%0d dp_off=%0d expected dark=16 dp_off=0", dark_n, p_off);
        end
    endtask

    task automatic test_raw();
        logic [31:0] rd, erd;
        int          lat;
        logic        a2;
        bus_access(1'b1, 1'b0, SEG_REG_RAW_LO, 32'h0000_00FF, rd, erd, lat, a2);
        bus_access(1'b1, 1'b0, SEG_REG_CTRL, 32'h3, rd, erd, lat, a2);
        @(negedge clk);
        checks++;
        if (seg !== {{(D-1){8'hFF}}, 8'h00}) begin
            failures++;
            $display("FAIL raw got=%h expected=%h", seg, {{(D-1){8'hFF}}, 8'h00});
        end
    endtask

    task automatic test_scroll();
        logic [31:0] rd, erd;
        int          lat;
        logic        a2;
        bus_access(1'b1, 1'b0, SEG_REG_BLINK, 32'h0, rd, erd, lat, a2);
        bus_access(1'b1, 1'b0, SEG_REG_DP, 32'h0, rd, erd, lat, a2);
        bus_access(1'b1, 1'b0, SEG_REG_HEX, 32'h0054_3210, rd, erd, lat, a2);
        bus_access(1'b1, 1'b0, SEG_REG_CTRL, 32'h5, rd, erd, lat, a2);
        repeat (8) @(negedge clk);
        checks++;
        if (seg[0] !== 8'h03) begin
            failures++;
            $display("FAIL scroll_pre got=%h expected=03", seg[0]);
        end
        @(negedge clk);
        checks++;
        if (seg[0] !== 8'h9F) begin
            failures++;
            $display("FAIL scroll_step got=%h expected=9f", seg[0]);
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            for (int i = 0; i < D; i++) begin
                checks++;
                if (seg[i] !== exp_seg[i]) begin
                    failures++;
                    $display("FAIL scroll c%0d digit%0d got=%h expected=%h", c, i, seg[i], exp_seg[i]);
                end
            end
        end
        bus_access(1'b1, 1'b0, SEG_REG_CTRL, 32'h1, rd, erd, lat, a2);
        @(negedge clk);
        checks++;
        if (seg[0] !== 8'h03 || seg[5] !== exp_seg[5]) begin
            failures++;
            $display("FAIL scroll_home got=%h,%h expected=03,%h", seg[0], seg[5], exp_seg[5]);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, wd;
        logic [2:0]  idx;
        logic        we, re, a2;
        int          lat;
        for (int it = 0; it < 60; it++) begin
            idx = 3'($urandom_range(0, 7));
            we  = 1'($urandom_range(0, 1));
            re  = we ? 1'($urandom_range(0, 1)) : 1'b1;
            wd  = $urandom;
            if (idx == SEG_REG_CTRL) wd[0] = ($urandom_range(0, 3) != 0);
            bus_access(we, re, idx, wd, rd, erd, lat, a2);
            checks++;
            if (lat !== 1 || a2 !== 1'b0 || rd !== erd) begin
                failures++;
                $display("FAIL rand_bus it%0d reg%0d lat=%0d ack2=%b rd=%h expected lat=1 ack2=0 rd=%h",
                         it, idx, lat, a2, rd, erd);
            end
            repeat ($urandom_range(1, 12)) begin
                @(negedge clk);
                for (int i = 0; i < D; i++) begin
                    checks++;
                    if (seg[i] !== exp_seg[i]) begin
                        failures++;
                        $display("FAIL rand_seg it%0d digit%0d got=%h expected=%h",
                                 it, i, seg[i], exp_seg[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd;
        int          lat;
        logic        a2;
        @(negedge clk);
        bus_addr  = {11'h0, SEG_REG_HEX, 2'b00};
        bus_wdata = 32'h00AB_CDEF;
        bus_we    = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus_ack !== 1'b1) begin
            failures++;
            $display("FAIL midrst_ack_before got=%b expected=1", bus_ack);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus_ack !== 1'b0 || seg !== {D{8'hFF}}) begin
            failures++;
            $display("FAIL midrst_async ack=%b seg=%h expected ack=0 seg all ff", bus_ack, seg);
        end
        bus_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            bus_access(1'b0, 1'b1, 3'(r), 32'h0, rd, erd, lat, a2);
            checks++;
            if (lat !== 1 || rd !== 32'h0) begin
                failures++;
                $display("FAIL midrst_read reg%0d lat=%0d rd=%h expected lat=1 rd=0", r, lat, rd);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        test_reset();
        test_hex();
        test_blink();
        test_raw();
        test_scroll();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
